cnt_seq_checker: RTL and testbench
==================================

Name: cnt_seq_checker

Overview:
- Receive-side checker for the free-running up-counter output bus: samples the count stream and verifies every accepted sample equals the previous accepted sample + 1 (mod 2^WIDTH).
- Acquires lock after a run of correct increments, then flags each sequence break.
- Sits at the consuming end of the counter's count bus, in silicon or as a bench monitor.

Parameters:
- WIDTH, 4, width of the monitored count bus.
- LOCK_CYCLES, 4, consecutive correct increments required to declare lock (1..15).
- ERR_W, 8, width of the error event counter (optional feature only).

Ports:
- iclk  input  1  clock, rising edge.
- irst_n  input  1  reset, asynchronous, active-low.
- ien  input  1  checker enable.
- ivalid  input  1  icnt qualifier; a sample is taken only when ien=1 and ivalid=1.
- icnt  input  WIDTH  count value under check.
- iclr  input  1  clears oerr_sticky.
- olocked  output  1  high while state=LOCKED.
- oerr  output  1  one-cycle pulse per detected sequence break.
- oerr_sticky  output  1  set on any oerr; held until iclr or reset.
- ostate  output  2  0=UNLOCKED, 1=ACQUIRE, 2=LOCKED, 3=FAULT.
- oexp  output  WIDTH  next expected value (prev+1); 0 in UNLOCKED.
- oerr_cnt  output  ERR_W  error event count (present only with CNT_CHK_ERRCNT_EN).

Behaviour:
- Registers and outputs:
  - All state is registered; outputs reflect the edge that took the sample (one-cycle latency).
  - irst_n low at any time, including mid-operation: immediately clears prev, good-run counter, state, olocked, oerr, oerr_sticky, oexp and oerr_cnt to 0.
- Arithmetic:
  - Expected value = prev+1, truncated to WIDTH bits, so max→0 wrap is a correct increment.
  - Good-run counter saturates at LOCK_CYCLES.
- Enable and gaps:
  - ien=0: next state UNLOCKED; good-run cleared; oerr forced 0; oerr_sticky and oerr_cnt retained.
  - ivalid=0 with ien=1: no sample; state, prev and good-run hold; oerr=0. Gaps are never errors.
- UNLOCKED: on sample, prev<=icnt, good<=0, go to ACQUIRE. No error possible.
- ACQUIRE: on sample, prev<=icnt.
  - Match: good<=good+1; go to LOCKED when the incremented value reaches LOCK_CYCLES.
  - Mismatch: good<=0, stay in ACQUIRE. No oerr.
- LOCKED: on sample, prev<=icnt.
  - Match: stay.
  - Mismatch: oerr=1 for one cycle, oerr_sticky<=1, go to FAULT.
- FAULT: on sample, prev<=icnt.
  - Match: good<=1, go to ACQUIRE.
  - Mismatch: oerr pulses again, stay in FAULT.
- iclr:
  - Clears oerr_sticky on the next edge.
  - If an error is detected on the same edge, set wins and sticky stays 1.
- olocked = (ostate==2), registered with state.
- LOCK_CYCLES=1: lock on the first correct increment after the first sample.

Optional Feature:
- Macro CNT_CHK_ERRCNT_EN.
- Defined:
  - oerr_cnt port exists.
  - Increments by 1 on every oerr pulse and saturates at 2^ERR_W-1 (no wrap).
  - Cleared by reset and by iclr; error+iclr on the same edge yields 1.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: irst_n=0 for 100 ns (10 ns clock) with icnt toggling → ostate=0, olocked=0, oerr=0, oerr_sticky=0, oexp=0 throughout; release → still 0 until the first sample.
- Lock: ien=ivalid=1, icnt=0,1,2,3,4 on consecutive edges → ostate 1 after the 0 sample; olocked=1 after the edge sampling 4; oexp=5.
- Wrap: locked, icnt=13,14,15,0,1 → no oerr, olocked stays 1, oexp=2 at end.
- Break and recovery: locked at 5, then icnt=7 → oerr exactly one cycle, oerr_sticky=1, ostate=3. Then 8 → ACQUIRE, good=1. Then 9,10,11 → olocked=1 after 11. oerr_sticky still 1.
- Gaps and enable: locked at 3, ivalid=0 for 3 cycles, then icnt=4 → no oerr. Drop ien for 1 cycle → ostate=0; resample 9 → ACQUIRE, no error.
- Clear and counter: iclr=1 on the same edge as a mismatch → oerr_sticky stays 1 and oerr_cnt=1; iclr alone → both 0. With macro and ERR_W=2: 5 mismatches in FAULT → oerr_cnt=3.

Source files
------------

// File: rtl/cnt_seq_checker_if.sv
// Count-stream bus between a counter source and its sequence checker.
// Carries the sample qualifiers, the sticky-clear request and the checker status.
// CNT_CHK_ERRCNT_EN adds the error event counter to the bus.
interface cnt_seq_checker_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    logic             ien;
    logic             ivalid;
    logic [WIDTH-1:0] icnt;
    logic             iclr;
    logic             olocked;
    logic             oerr;
    logic             oerr_sticky;
    logic [1:0]       ostate;
    logic [WIDTH-1:0] oexp;
`ifdef CNT_CHK_ERRCNT_EN
    logic [ERR_W-1:0] oerr_cnt;
`endif

    // Source side: drives the count stream, observes the checker status.
    modport master (
        output ien, ivalid, icnt, iclr,
        input  olocked, oerr, oerr_sticky, ostate, oexp
`ifdef CNT_CHK_ERRCNT_EN
        , input oerr_cnt
`endif
    );

    // Checker side.
    modport slave (
        input  ien, ivalid, icnt, iclr,
        output olocked, oerr, oerr_sticky, ostate, oexp
`ifdef CNT_CHK_ERRCNT_EN
        , output oerr_cnt
`endif
    );
endinterface

// File: rtl/cnt_seq_checker.sv
// Sequence checker: verifies each accepted sample equals previous accepted sample + 1.
// Latency: one cycle, all outputs registered with the edge that took the sample.
// Never backpressures; ivalid=0 gaps are ignored. CNT_CHK_ERRCNT_EN adds oerr_cnt.
module cnt_seq_checker #(
    parameter int WIDTH       = 4,
    parameter int LOCK_CYCLES = 4,
    parameter int ERR_W       = 8
) (
    input  logic             iclk,
    input  logic             irst_n,
    cnt_seq_checker_if.slave bus
);
    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_FAULT    = 2'd3
    } state_t;

    localparam logic [3:0] LOCK_C = 4'(LOCK_CYCLES);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [3:0]       good_q, good_d;
    logic             err_q, err_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] exp_w;
    logic             match;

    // Expected value wraps naturally at the bus width, so max->0 counts as a match.
    assign exp_w = prev_q + 1'b1;
    assign match = (bus.icnt == exp_w);

    // Next-state: sequence FSM, previous-sample capture, good-run counter, error pulse.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        good_d  = good_q;
        err_d   = 1'b0;
        if (!bus.ien) begin
            state_d = ST_UNLOCKED;
            good_d  = 4'd0;
        end else if (bus.ivalid) begin
            prev_d = bus.icnt;
            case (state_q)
                ST_UNLOCKED: begin
                    good_d  = 4'd0;
                    state_d = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (match) begin
                        // good_q never exceeds LOCK_C, so this also saturates it.
                        if (good_q >= LOCK_C - 4'd1) begin
                            good_d  = LOCK_C;
                            state_d = ST_LOCKED;
                        end else begin
                            good_d = good_q + 4'd1;
                        end
                    end else begin
                        good_d = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (!match) begin
                        err_d   = 1'b1;
                        state_d = ST_FAULT;
                    end
                end
                default: begin
                    if (match) begin
                        good_d  = 4'd1;
                        state_d = ST_ACQUIRE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // Sticky flag: a newly detected error wins over a same-edge clear.
    always_comb begin
        sticky_d = sticky_q;
        if (err_d) begin
            sticky_d = 1'b1;
        end else if (bus.iclr) begin
            sticky_d = 1'b0;
        end
    end

    // Core state registers.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q  <= ST_UNLOCKED;
            prev_q   <= '0;
            good_q   <= 4'd0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            good_q   <= good_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.ostate      = state_q;
    assign bus.olocked     = (state_q == ST_LOCKED);
    assign bus.oerr        = err_q;
    assign bus.oerr_sticky = sticky_q;
    assign bus.oexp        = (state_q == ST_UNLOCKED) ? '0 : exp_w;

`ifdef CNT_CHK_ERRCNT_EN
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    // Saturating error event counter; error and clear on one edge leaves a count of 1.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d) begin
            if (bus.iclr) begin
                err_cnt_d = {{(ERR_W-1){1'b0}}, 1'b1};
            end else if (err_cnt_q != {ERR_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end else if (bus.iclr) begin
            err_cnt_d = '0;
        end
    end

    // Error counter register.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.oerr_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_cnt_seq_checker.sv
// Directed bench for cnt_seq_checker: reset, lock, wrap, break/recovery, gaps, clear.
// Outputs are sampled 1 ns after the rising edge; inputs change at the same point.
// Error-counter steps run only when CNT_CHK_ERRCNT_EN is defined.
module tb_cnt_seq_checker;
    localparam int WIDTH = 4;
    localparam int LOCK  = 4;
    localparam int ERR_W = 2;

    logic iclk;
    logic irst_n;
    int   checks;
    int   failures;

    cnt_seq_checker_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

    cnt_seq_checker #(
        .WIDTH      (WIDTH),
        .LOCK_CYCLES(LOCK),
        .ERR_W      (ERR_W)
    ) dut (
        .iclk  (iclk),
        .irst_n(irst_n),
        .bus   (bus)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic smp(input logic [3:0] cnt);
        bus.ien    = 1'b1;
        bus.ivalid = 1'b1;
        bus.icnt   = cnt;
        tick();
    endtask

    task automatic st(input string tag, input logic [1:0] s, input logic e,
                      input logic sk, input logic [3:0] ex);
        check({tag, ".state"},  32'(bus.ostate),      32'(s));
        check({tag, ".locked"}, 32'(bus.olocked),     32'(s == 2'd2));
        check({tag, ".err"},    32'(bus.oerr),        32'(e));
        check({tag, ".sticky"}, 32'(bus.oerr_sticky), 32'(sk));
        check({tag, ".exp"},    32'(bus.oexp),        32'(ex));
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        irst_n     = 1'b0;
        bus.ien    = 1'b1;
        bus.ivalid = 1'b1;
        bus.icnt   = 4'd0;
        bus.iclr   = 1'b0;

        // Reset held 100 ns with a live, incrementing stream.
        #1;
        for (int i = 0; i < 10; i++) begin
            bus.icnt = 4'(i);
            tick();
            st("rst", 2'd0, 1'b0, 1'b0, 4'd0);
        end
        bus.ivalid = 1'b0;
        irst_n     = 1'b1;
        tick();
        st("post_rst", 2'd0, 1'b0, 1'b0, 4'd0);

        // Lock on 0..4.
        smp(4'd0); st("lk0", 2'd1, 1'b0, 1'b0, 4'd1);
        smp(4'd1); st("lk1", 2'd1, 1'b0, 1'b0, 4'd2);
        smp(4'd2); st("lk2", 2'd1, 1'b0, 1'b0, 4'd3);
        smp(4'd3); st("lk3", 2'd1, 1'b0, 1'b0, 4'd4);
        smp(4'd4); st("lk4", 2'd2, 1'b0, 1'b0, 4'd5);
        smp(4'd5); st("lk5", 2'd2, 1'b0, 1'b0, 4'd6);

        // Break at 7, recover through 8..11.
        smp(4'd7);  st("brk",  2'd3, 1'b1, 1'b1, 4'd8);
`ifdef CNT_CHK_ERRCNT_EN
        check("brk.cnt", 32'(bus.oerr_cnt), 32'd1);
`endif
        smp(4'd8);  st("rec8",  2'd1, 1'b0, 1'b1, 4'd9);
        smp(4'd9);  st("rec9",  2'd1, 1'b0, 1'b1, 4'd10);
        smp(4'd10); st("rec10", 2'd1, 1'b0, 1'b1, 4'd11);
        smp(4'd11); st("rec11", 2'd2, 1'b0, 1'b1, 4'd12);

        // Wrap 15 -> 0 while locked.
        smp(4'd12); st("w12", 2'd2, 1'b0, 1'b1, 4'd13);
        smp(4'd13); st("w13", 2'd2, 1'b0, 1'b1, 4'd14);
        smp(4'd14); st("w14", 2'd2, 1'b0, 1'b1, 4'd15);
        smp(4'd15); st("w15", 2'd2, 1'b0, 1'b1, 4'd0);
        smp(4'd0);  st("w0",  2'd2, 1'b0, 1'b1, 4'd1);
        smp(4'd1);  st("w1",  2'd2, 1'b0, 1'b1, 4'd2);

        // Gaps while locked at 3, then resume at 4.
        smp(4'd2);  smp(4'd3);
        bus.ivalid = 1'b0;
        bus.icnt   = 4'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            st("gap", 2'd2, 1'b0, 1'b1, 4'd4);
        end
        smp(4'd4); st("gap_end", 2'd2, 1'b0, 1'b1, 4'd5);

        // Enable drop, then resample at 9.
        bus.ien = 1'b0;
        tick();    st("en_off", 2'd0, 1'b0, 1'b1, 4'd0);
        smp(4'd9); st("en_on",  2'd1, 1'b0, 1'b1, 4'd10);

        // Clear alone.
        bus.ivalid = 1'b0;
        bus.iclr   = 1'b1;
        tick();
        bus.iclr   = 1'b0;
        st("clr", 2'd1, 1'b0, 1'b0, 4'd10);
`ifdef CNT_CHK_ERRCNT_EN
        check("clr.cnt", 32'(bus.oerr_cnt), 32'd0);
`endif

        // Relock, then clear on the same edge as a mismatch.
        smp(4'd10); smp(4'd11); smp(4'd12); smp(4'd13);
        st("relock", 2'd2, 1'b0, 1'b0, 4'd14);
        bus.iclr = 1'b1;
        smp(4'd5);
        st("clr_err", 2'd3, 1'b1, 1'b1, 4'd6);
`ifdef CNT_CHK_ERRCNT_EN
        check("clr_err.cnt", 32'(bus.oerr_cnt), 32'd1);
`endif
        bus.ivalid = 1'b0;
        tick();
        bus.iclr   = 1'b0;
        st("clr2", 2'd3, 1'b0, 1'b0, 4'd6);
`ifdef CNT_CHK_ERRCNT_EN
        check("clr2.cnt", 32'(bus.oerr_cnt), 32'd0);
`endif

        // Repeated mismatches in FAULT: pulse every sample, counter saturates.
        for (int i = 0; i < 5; i++) begin
            smp(4'd0);
            st("flt", 2'd3, 1'b1, 1'b1, 4'd1);
`ifdef CNT_CHK_ERRCNT_EN
            check("flt.cnt", 32'(bus.oerr_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
`endif
        end

        // Asynchronous reset mid-cycle.
        bus.ivalid = 1'b0;
        #3;
        irst_n = 1'b0;
        #1;
        st("arst", 2'd0, 1'b0, 1'b0, 4'd0);
`ifdef CNT_CHK_ERRCNT_EN
        check("arst.cnt", 32'(bus.oerr_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
